// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with registered reads, optional write-to-read
// bypass, optional hardwired-zero register 0, and a per-register pending scoreboard.
module register_file_2r1w #(
  parameter int ADDRESS_LEN = 4,
  parameter int DATA_LEN    = 16,
  parameter int ZERO_REG    = 0,
  parameter int BYPASS      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rf_wr_en,
  input  logic [ADDRESS_LEN-1:0] wr_addr,
  input  logic [DATA_LEN-1:0]    wr_data,
  input  logic                   rd_en_a,
  input  logic [ADDRESS_LEN-1:0] rd_addr_a,
  output logic [DATA_LEN-1:0]    rd_data_a,
  output logic                   rd_valid_a,
  output logic                   pend_a,
  input  logic                   rd_en_b,
  input  logic [ADDRESS_LEN-1:0] rd_addr_b,
  output logic [DATA_LEN-1:0]    rd_data_b,
  output logic                   rd_valid_b,
  output logic                   pend_b,
  input  logic                   pend_set_en,
  input  logic [ADDRESS_LEN-1:0] pend_set_addr
);

  localparam int DEPTH = 2 ** ADDRESS_LEN;
  localparam logic [ADDRESS_LEN-1:0] ADDR_ZERO = {ADDRESS_LEN{1'b0}};
  localparam logic [DEPTH-1:0]       ONE_HOT_0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DATA_LEN-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]    pend_r;
  logic [DEPTH-1:0]    pend_next_s;
  logic [DEPTH-1:0]    clr_mask_s;
  logic [DEPTH-1:0]    set_mask_s;
  logic                wr_ok_s;
  logic                set_ok_s;
  logic [DATA_LEN-1:0] rd_data_a_s;
  logic [DATA_LEN-1:0] rd_data_b_s;
  logic                rd_pend_a_s;
  logic                rd_pend_b_s;

  // Qualify write/set against the hardwired-zero register and build the next pending vector
  always_comb begin
    wr_ok_s  = rf_wr_en    & ~((ZERO_REG == 1) && (wr_addr == ADDR_ZERO));
    set_ok_s = pend_set_en & ~((ZERO_REG == 1) && (pend_set_addr == ADDR_ZERO));
    clr_mask_s = wr_ok_s  ? (ONE_HOT_0 << wr_addr)       : {DEPTH{1'b0}};
    set_mask_s = set_ok_s ? (ONE_HOT_0 << pend_set_addr) : {DEPTH{1'b0}};
    // Set is applied after clear so a same-cycle set on the written register wins
    pend_next_s = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // Port A read mux: zero register, then bypass, then stored state
  always_comb begin
    rd_data_a_s = mem_r[rd_addr_a];
    rd_pend_a_s = pend_r[rd_addr_a];
    if ((ZERO_REG == 1) && (rd_addr_a == ADDR_ZERO)) begin
      rd_data_a_s = {DATA_LEN{1'b0}};
      rd_pend_a_s = 1'b0;
    end else if ((BYPASS == 1) && rf_wr_en && (rd_addr_a == wr_addr)) begin
      rd_data_a_s = wr_data;
      rd_pend_a_s = pend_next_s[rd_addr_a];
    end else begin
      rd_data_a_s = mem_r[rd_addr_a];
      rd_pend_a_s = pend_r[rd_addr_a];
    end
  end

  // Port B read mux: identical to port A
  always_comb begin
    rd_data_b_s = mem_r[rd_addr_b];
    rd_pend_b_s = pend_r[rd_addr_b];
    if ((ZERO_REG == 1) && (rd_addr_b == ADDR_ZERO)) begin
      rd_data_b_s = {DATA_LEN{1'b0}};
      rd_pend_b_s = 1'b0;
    end else if ((BYPASS == 1) && rf_wr_en && (rd_addr_b == wr_addr)) begin
      rd_data_b_s = wr_data;
      rd_pend_b_s = pend_next_s[rd_addr_b];
    end else begin
      rd_data_b_s = mem_r[rd_addr_b];
      rd_pend_b_s = pend_r[rd_addr_b];
    end
  end

  // Storage, pending vector and registered read outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_LEN{1'b0}};
      end
      pend_r     <= {DEPTH{1'b0}};
      rd_data_a  <= {DATA_LEN{1'b0}};
      rd_data_b  <= {DATA_LEN{1'b0}};
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_addr] <= wr_data;
      end
      pend_r     <= pend_next_s;
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) begin
        rd_data_a <= rd_data_a_s;
        pend_a    <= rd_pend_a_s;
      end
      if (rd_en_b) begin
        rd_data_b <= rd_data_b_s;
        pend_b    <= rd_pend_b_s;
      end
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench: one 4x16 bypassing instance and one 5x32 non-bypassing,
// zero-register instance, each checked against a bench-side register model.
module tb_register_file_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        w1_en;   logic [3:0] w1_addr; logic [15:0] w1_data;
  logic        a1_en;   logic [3:0] a1_addr; logic [15:0] a1_data; logic a1_valid; logic a1_pend;
  logic        b1_en;   logic [3:0] b1_addr; logic [15:0] b1_data; logic b1_valid; logic b1_pend;
  logic        ps1_en;  logic [3:0] ps1_addr;

  logic        w2_en;   logic [4:0] w2_addr; logic [31:0] w2_data;
  logic        a2_en;   logic [4:0] a2_addr; logic [31:0] a2_data; logic a2_valid; logic a2_pend;
  logic        b2_en;   logic [4:0] b2_addr; logic [31:0] b2_data; logic b2_valid; logic b2_pend;
  logic        ps2_en;  logic [4:0] ps2_addr;

  register_file_2r1w #(.ADDRESS_LEN(4), .DATA_LEN(16), .ZERO_REG(0), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst),
    .rf_wr_en(w1_en), .wr_addr(w1_addr), .wr_data(w1_data),
    .rd_en_a(a1_en), .rd_addr_a(a1_addr), .rd_data_a(a1_data), .rd_valid_a(a1_valid), .pend_a(a1_pend),
    .rd_en_b(b1_en), .rd_addr_b(b1_addr), .rd_data_b(b1_data), .rd_valid_b(b1_valid), .pend_b(b1_pend),
    .pend_set_en(ps1_en), .pend_set_addr(ps1_addr)
  );

  register_file_2r1w #(.ADDRESS_LEN(5), .DATA_LEN(32), .ZERO_REG(1), .BYPASS(0)) dut2 (
    .clk(clk), .rst(rst),
    .rf_wr_en(w2_en), .wr_addr(w2_addr), .wr_data(w2_data),
    .rd_en_a(a2_en), .rd_addr_a(a2_addr), .rd_data_a(a2_data), .rd_valid_a(a2_valid), .pend_a(a2_pend),
    .rd_en_b(b2_en), .rd_addr_b(b2_addr), .rd_data_b(b2_data), .rd_valid_b(b2_valid), .pend_b(b2_pend),
    .pend_set_en(ps2_en), .pend_set_addr(ps2_addr)
  );

  int checks = 0;
  int passed = 0;
  logic [15:0] m1 [16];
  logic [31:0] m2 [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle of dut1 stimulus, then sample 1 time unit after the edge
  task automatic op1(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic ps, input logic [3:0] pa,
                     input logic ra, input logic [3:0] aa, input logic rb, input logic [3:0] ab);
    w1_en = we; w1_addr = wa; w1_data = wd; ps1_en = ps; ps1_addr = pa;
    a1_en = ra; a1_addr = aa; b1_en = rb; b1_addr = ab;
    @(posedge clk); #1;
  endtask

  task automatic op2(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ps, input logic [4:0] pa,
                     input logic ra, input logic [4:0] aa, input logic rb, input logic [4:0] ab);
    w2_en = we; w2_addr = wa; w2_data = wd; ps2_en = ps; ps2_addr = pa;
    a2_en = ra; a2_addr = aa; b2_en = rb; b2_addr = ab;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0]  wa1;
    logic [15:0] wd1;
    logic [4:0]  wa2;
    logic [31:0] wd2;

    rst = 1'b1;
    w1_en = 1'b0; w1_addr = 4'd0; w1_data = 16'h0; ps1_en = 1'b0; ps1_addr = 4'd0;
    a1_en = 1'b0; a1_addr = 4'd0; b1_en = 1'b0; b1_addr = 4'd0;
    w2_en = 1'b0; w2_addr = 5'd0; w2_data = 32'h0; ps2_en = 1'b0; ps2_addr = 5'd0;
    a2_en = 1'b0; a2_addr = 5'd0; b2_en = 1'b0; b2_addr = 5'd0;
    for (int i = 0; i < 16; i++) m1[i] = 16'h0000;
    for (int i = 0; i < 32; i++) m2[i] = 32'h0;

    // ---- reset ----
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_data_a", 32'(a1_data), 32'h0);
    chk("rst_data_b", 32'(b1_data), 32'h0);
    chk("rst_valid_a", 32'(a1_valid), 32'h0);
    chk("rst_valid_b", 32'(b1_valid), 32'h0);
    chk("rst_pend_a", 32'(a1_pend), 32'h0);
    chk("rst_pend_b", 32'(b1_pend), 32'h0);
    rst = 1'b0;

    // ---- dut1 random write / read-back ----
    for (int i = 0; i < 100; i++) begin
      wa1 = 4'($urandom_range(0, 15));
      wd1 = 16'($urandom);
      op1(1'b1, wa1, wd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
      chk("wr_no_valid", 32'(a1_valid), 32'h0);
      m1[wa1] = wd1;
    end
    for (int i = 0; i < 16; i++) begin
      op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'(i), 1'b1, 4'(15 - i));
      chk("rand_data_a", 32'(a1_data), 32'(m1[i]));
      chk("rand_data_b", 32'(b1_data), 32'(m1[15 - i]));
      chk("rand_valid_a", 32'(a1_valid), 32'h1);
      chk("rand_valid_b", 32'(b1_valid), 32'h1);
    end
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b0, 4'd2);
    chk("idle_valid_a", 32'(a1_valid), 32'h0);
    chk("hold_data_a", 32'(a1_data), 32'(m1[15]));
    chk("hold_data_b", 32'(b1_data), 32'(m1[0]));

    // ---- register 0 is ordinary when ZERO_REG=0 ----
    op1(1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    op1(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0);
    chk("r0_data", 32'(a1_data), 32'h1234);
    chk("r0_pend", 32'(a1_pend), 32'h1);

    // ---- bypass ----
    op1(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 4'd5);
    chk("byp_data_a", 32'(a1_data), 32'hBEEF);
    chk("byp_data_b", 32'(b1_data), 32'hBEEF);
    chk("byp_pend_a", 32'(a1_pend), 32'h0);

    // ---- scoreboard ----
    op1(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0);
    chk("sb_set_pend", 32'(a1_pend), 32'h1);
    op1(1'b1, 4'd3, 16'h00AA, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0);
    chk("sb_wr_pend", 32'(a1_pend), 32'h0);
    chk("sb_wr_data", 32'(a1_data), 32'h00AA);
    op1(1'b1, 4'd3, 16'h5A5A, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0);
    chk("sb_both_pend", 32'(a1_pend), 32'h1);
    chk("sb_both_data", 32'(a1_data), 32'h5A5A);
    op1(1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3);
    chk("sb_byp_set_data", 32'(b1_data), 32'h1111);
    chk("sb_byp_set_pend_a", 32'(a1_pend), 32'h1);
    chk("sb_byp_set_pend_b", 32'(b1_pend), 32'h1);
    op1(1'b1, 4'd3, 16'h2222, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0);
    chk("sb_byp_clr_data", 32'(a1_data), 32'h2222);
    chk("sb_byp_clr_pend", 32'(a1_pend), 32'h0);

    // ---- reset mid-traffic ----
    op1(1'b1, 4'd7, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    rst = 1'b1;
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(a1_valid), 32'h0);
    chk("mid_rst_data", 32'(a1_data), 32'h0);
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b1, 4'd0);
    chk("post_rst_r7", 32'(a1_data), 32'h0);
    chk("post_rst_r0", 32'(b1_data), 32'h0);
    chk("post_rst_pend", 32'(b1_pend), 32'h0);
    op1(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

    // ---- dut2: no bypass ----
    op2(1'b1, 5'd5, 32'hBEEF, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5);
    chk("nb_data_a", a2_data, 32'h0);
    chk("nb_data_b", b2_data, 32'h0);
    op2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5);
    chk("nb_next_a", a2_data, 32'hBEEF);
    chk("nb_next_b", b2_data, 32'hBEEF);
    m2[5] = 32'hBEEF;
    op2(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("nb_set_pre_pend", 32'(a2_pend), 32'h0);
    op2(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("nb_wr_pre_pend", 32'(a2_pend), 32'h1);
    chk("nb_wr_pre_data", a2_data, 32'h0);
    op2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("nb_wr_post_pend", 32'(a2_pend), 32'h0);
    chk("nb_wr_post_data", a2_data, 32'h77);
    m2[3] = 32'h77;

    // ---- dut2: hardwired zero register ----
    op2(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    op2(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    op2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    chk("zr_data", a2_data, 32'h0);
    chk("zr_pend", 32'(a2_pend), 32'h0);

    // ---- dut2: wide random write / read-back, every register written ----
    for (int i = 0; i < 32; i++) begin
      wd2 = $urandom;
      op2(1'b1, 5'(i), wd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      if (i != 0) m2[i] = wd2;
    end
    for (int i = 0; i < 60; i++) begin
      wa2 = 5'($urandom_range(1, 31));
      wd2 = $urandom;
      op2(1'b1, wa2, wd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      m2[wa2] = wd2;
    end
    for (int i = 0; i < 32; i++) begin
      op2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      chk("wide_data_a", a2_data, m2[i]);
      chk("wide_data_b", b2_data, m2[31 - i]);
      chk("wide_valid_b", 32'(b2_valid), 32'h1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

Parametrised two-read/one-write register file for the multi-cycle 16-bit processor datapath. It replaces the single-read-port register file so that both ALU operands can be fetched in one cycle. Reads are registered with one-cycle latency. It adds a configurable write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard that the control FSM uses to stall on outstanding writes.

## Interface
- ADDRESS_LEN, 4, address width; depth = 2**ADDRESS_LEN registers
- DATA_LEN, 16, register width in bits
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and pending-set
- BYPASS, 1, 1 = same-cycle write forwarded to a registered read; 0 = read returns the pre-write value

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rf_wr_en  in  1  write enable
- wr_addr  in  ADDRESS_LEN  write address
- wr_data  in  DATA_LEN  write data
- rd_en_a  in  1  port A read request
- rd_addr_a  in  ADDRESS_LEN  port A address
- rd_data_a  out  DATA_LEN  port A registered data
- rd_valid_a  out  1  port A data valid, one cycle after rd_en_a
- pend_a  out  1  pending status of the last port A address read
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b, pend_b  same as port A, for port B
- pend_set_en  in  1  mark a register as awaiting a write
- pend_set_addr  in  ADDRESS_LEN  register to mark

## Operation
- Storage: 2**ADDRESS_LEN x DATA_LEN registers, plus a 2**ADDRESS_LEN-bit pending vector.
- Reset (rst=1 at an edge):
  - All registers and pending bits are cleared to 0.
  - rd_data_a/b = 0, rd_valid_a/b = 0, pend_a/b = 0.
  - Reset overrides every write, set and read in the same cycle.
- Write: when rf_wr_en=1, mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Pending set: when pend_set_en=1, pending[pend_set_addr] <= 1.
  - If the write and the set hit the same address in the same cycle, set wins: the bit stays 1, and the data is still written.
- Read: when rd_en_x=1, rd_data_x <= mem[rd_addr_x] and pend_x <= pending[rd_addr_x].
  - When rd_en_x=0, rd_data_x and pend_x hold their values.
  - rd_valid_x <= rd_en_x every cycle.
- Bypass when BYPASS=1 and rd_addr_x == wr_addr with rf_wr_en=1:
  - rd_data_x <= wr_data.
  - pend_x reflects the post-update bit: 0, unless the same-cycle set also targets that address.
- When BYPASS=0, a read returns the pre-edge data and pending bit.
- Ports A and B are independent. Both may read the same address; both see identical data.
- ZERO_REG=1:
  - Writes and pending-sets to address 0 are dropped.
  - Reads of address 0 return data 0 and pend 0, with or without bypass.
- Addresses wrap naturally within ADDRESS_LEN bits. There are no out-of-range cases.

## Timing
- Read latency: 1 cycle. Present the address with rd_en at edge N; data, valid and pend are usable after edge N+1 settles.
- Write latency: 1 cycle. A read issued at the edge after the write returns the new value regardless of BYPASS.
- Throughput: one write plus two reads every cycle, with no stalls and no handshake back-pressure.
- Reset mid-operation: a read requested in the reset cycle is discarded (rd_valid=0 on the next cycle). Storage is zero afterwards.
- Output reset values: rd_data_a/b = 0, rd_valid_a/b = 0, pend_a/b = 0.

## Test plan
- Reset/write/read-back: hold rst for 10 cycles, then write 100 random (addr, data) pairs. Read each address on both ports. Required: every rd_data matches the bench model, and rd_valid pulses exactly one cycle after rd_en.
- Bypass: write 0xBEEF to R5 while rd_addr_a=rd_addr_b=5 in the same cycle. Required: with BYPASS=1, both ports return 0xBEEF next cycle; with BYPASS=0, both return the prior value (0x0000 after reset).
- Zero register: with ZERO_REG=1, write 0x1234 to R0, assert pend_set on R0, then read R0. Required: data 0x0000, pend 0. With ZERO_REG=0, the same sequence returns 0x1234 and pend 1.
- Scoreboard:
  - pend_set R3, then read R3. Required: pend_a=1.
  - Write R3 = 0x00AA, then read R3. Required: pend_a=0, data 0x00AA.
  - Set and write R3 in the same cycle, then read. Required: pend_a=1, data equals the written value.
- Reset mid-traffic: write R7 = 0xFFFF, then assert rst in the same cycle as rd_en_a on R7. Required: the next cycle shows rd_valid_a=0 and rd_data_a=0, and a later read of R7 returns 0x0000.
- Width generalisation: run the random test with ADDRESS_LEN=5, DATA_LEN=32. Required: all 32 registers are written and read back correctly, with no aliasing between addresses.
